oven_cook_controller: RTL and testbench

//  - Downstream of the oven input/display top. Accepts the operator's target temperature and cook time once entry is complete.
//  - Runs preheat, then a countdown cook with thermostat hysteresis, then an alarm.
//  - Models cavity temperature for the display. Drives the heater enable, current_temp, remaining_time and alarm.

---
 rtl/oven_pkg.sv | 33 +++
 rtl/oven_tick_gen.sv | 28 ++
 rtl/oven_cook_controller.sv | 172 +++++++++++++++++
 tb/tb_oven_cook_controller.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oven_pkg.sv
`default_nettype none
// ============================================================================
// oven_pkg : shared oven types, widths and temperature/time limits
// Rev 1.0
// ============================================================================
package oven_pkg;

  localparam int TEMP_W = 10;
  localparam int TIME_W = 13;

  localparam logic [TEMP_W-1:0] AMBIENT  = 10'd65;
  localparam logic [TEMP_W-1:0] MAX_TEMP = 10'd500;
  localparam logic [TIME_W-1:0] MAX_TIME = 13'd1800;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREHEAT = 2'd1,
    COOK    = 2'd2,
    DONE    = 2'd3
  } cook_state_t;

  function automatic logic [TEMP_W-1:0] clamp_temp(input logic [TEMP_W-1:0] t);
    if (t < AMBIENT)       return AMBIENT;
    else if (t > MAX_TEMP) return MAX_TEMP;
    else                   return t;
  endfunction

  function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] t);
    return (t > MAX_TIME) ? MAX_TIME : t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oven_tick_gen.sv
`default_nettype none
// ============================================================================
// oven_tick_gen : free-running prescaler, one-cycle tick every TICK_CYCLES clocks
// Rev 1.0
// ============================================================================
module oven_tick_gen #(
  parameter int unsigned TICK_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CNT_W'(1);
  end

  assign tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/oven_cook_controller.sv
`default_nettype none
// ============================================================================
// oven_cook_controller : preheat / thermostat cook / alarm sequencer with a
// cavity temperature model. Optional door interlock: DOOR_INTERLOCK_EN.
// Rev 1.0
// ============================================================================
module oven_cook_controller
  import oven_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 25_000_000,
  parameter int unsigned HEAT_RATE   = 5,
  parameter int unsigned COOL_RATE   = 2,
  parameter int unsigned HYST        = 10,
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cancel,
  input  logic              alarm_ack,
`ifdef DOOR_INTERLOCK_EN
  input  logic              door_open,
`endif
  input  logic [TEMP_W-1:0] target_temp,
  input  logic [TIME_W-1:0] target_time,
  output logic              heater,
  output logic [TEMP_W-1:0] current_temp,
  output logic [TIME_W-1:0] remaining_time,
  output logic              busy,
  output logic              alarm
);

  typedef logic [TEMP_W:0] temp_ext_t;

  localparam temp_ext_t HEAT_STEP = temp_ext_t'(HEAT_RATE);
  localparam temp_ext_t COOL_STEP = temp_ext_t'(COOL_RATE);
  localparam temp_ext_t HYST_BAND = temp_ext_t'(HYST);
  localparam int unsigned ACNT_W  = $clog2(ALARM_TICKS + 1);
  localparam logic [ACNT_W-1:0] ALARM_LAST = ACNT_W'(ALARM_TICKS - 1);

  cook_state_t       state, state_nxt;
  logic              heat_req, heat_req_nxt;
  logic              heater_nxt, alarm_nxt;
  logic [TEMP_W-1:0] temp, temp_nxt, target, target_nxt;
  logic [TIME_W-1:0] rem, rem_nxt;
  logic [ACNT_W-1:0] alarm_cnt, alarm_cnt_nxt;
  logic              tick, door_hold;
  temp_ext_t         temp_up, temp_dn, target_low;

  oven_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

`ifdef DOOR_INTERLOCK_EN
  assign door_hold = door_open;
`else
  assign door_hold = 1'b0;
`endif

  assign temp_up    = {1'b0, temp} + HEAT_STEP;
  assign temp_dn    = {1'b0, temp} - COOL_STEP;
  assign target_low = {1'b0, target} - HYST_BAND;

  // Model follows the heater as registered, so a tick on a transition edge
  // still sees the pre-transition element state.
  always_comb begin
    temp_nxt = temp;
    if (tick) begin
      if (heater) temp_nxt = (temp_up > temp_ext_t'(MAX_TEMP)) ? MAX_TEMP : temp_up[TEMP_W-1:0];
      else        temp_nxt = (temp_dn < temp_ext_t'(AMBIENT))  ? AMBIENT  : temp_dn[TEMP_W-1:0];
    end
  end

  always_comb begin
    state_nxt     = state;
    heat_req_nxt  = heat_req;
    alarm_nxt     = alarm;
    rem_nxt       = rem;
    target_nxt    = target;
    alarm_cnt_nxt = alarm_cnt;
    if (cancel) begin
      state_nxt    = IDLE;
      heat_req_nxt = 1'b0;
      alarm_nxt    = 1'b0;
      rem_nxt      = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !door_hold) begin
            state_nxt    = PREHEAT;
            target_nxt   = clamp_temp(target_temp);
            rem_nxt      = clamp_time(target_time);
            heat_req_nxt = 1'b1;
          end
        end
        PREHEAT: begin
          if (tick && (temp_nxt >= target)) begin
            state_nxt    = COOK;
            heat_req_nxt = 1'b0;
          end
        end
        COOK: begin
          if (rem == '0) begin
            state_nxt     = DONE;
            heat_req_nxt  = 1'b0;
            alarm_nxt     = 1'b1;
            alarm_cnt_nxt = '0;
          end else begin
            if (temp_nxt >= target)                 heat_req_nxt = 1'b0;
            else if ({1'b0, temp_nxt} < target_low) heat_req_nxt = 1'b1;
            if (tick && !door_hold) begin
              rem_nxt = rem - TIME_W'(1);
              if (rem == TIME_W'(1)) begin
                state_nxt     = DONE;
                heat_req_nxt  = 1'b0;
                alarm_nxt     = 1'b1;
                alarm_cnt_nxt = '0;
              end
            end
          end
        end
        DONE: begin
          rem_nxt = '0;
          if (alarm_ack) begin
            state_nxt = IDLE;
            alarm_nxt = 1'b0;
          end else if (tick) begin
            if (alarm_cnt == ALARM_LAST) begin
              state_nxt = IDLE;
              alarm_nxt = 1'b0;
            end else begin
              alarm_cnt_nxt = alarm_cnt + ACNT_W'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    // An open door masks the element without disturbing the thermostat demand.
    heater_nxt = ((state_nxt == PREHEAT) || (state_nxt == COOK)) && heat_req_nxt && !door_hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      heat_req  <= 1'b0;
      heater    <= 1'b0;
      temp      <= AMBIENT;
      target    <= AMBIENT;
      rem       <= '0;
      alarm     <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      state     <= state_nxt;
      heat_req  <= heat_req_nxt;
      heater    <= heater_nxt;
      temp      <= temp_nxt;
      target    <= target_nxt;
      rem       <= rem_nxt;
      alarm     <= alarm_nxt;
      alarm_cnt <= alarm_cnt_nxt;
    end
  end

  assign current_temp   = temp;
  assign remaining_time = rem;
  assign busy           = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_oven_cook_controller.sv
`default_nettype none
// ============================================================================
// tb_oven_cook_controller : randomized self-checking bench with a behavioural
// oven model. Rev 1.0
// ============================================================================
module tb_oven_cook_controller;

  localparam int TICK_CYCLES = 4;
  localparam int AMBIENT     = 65;
  localparam int MAX_TEMP    = 500;
  localparam int MAX_TIME    = 1800;
  localparam int HEAT_RATE   = 5;
  localparam int COOL_RATE   = 2;
  localparam int HYST        = 10;
  localparam int ALARM_TICKS = 10;
`ifdef DOOR_INTERLOCK_EN
  localparam bit DOOR_EN = 1'b1;
`else
  localparam bit DOOR_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_PRE = 1, M_COOK = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0, start = 1'b0, cancel = 1'b0, alarm_ack = 1'b0, door_open = 1'b0;
  logic [9:0]  target_temp = '0;
  logic [12:0] target_time = '0;
  logic        heater, busy, alarm;
  logic [9:0]  current_temp;
  logic [12:0] remaining_time;

  int checks = 0;
  int errors = 0;

  int m_mode, m_pre, m_temp, m_tgt, m_rem, m_acnt;
  bit m_req, m_heat, m_alarm;

  always #5 clk = ~clk;

  oven_cook_controller #(.TICK_CYCLES(TICK_CYCLES)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cancel         (cancel),
    .alarm_ack      (alarm_ack),
`ifdef DOOR_INTERLOCK_EN
    .door_open      (door_open),
`endif
    .target_temp    (target_temp),
    .target_time    (target_time),
    .heater         (heater),
    .current_temp   (current_temp),
    .remaining_time (remaining_time),
    .busy           (busy),
    .alarm          (alarm)
  );

  function automatic int clamp_t(input int t);
    return (t < AMBIENT) ? AMBIENT : ((t > MAX_TEMP) ? MAX_TEMP : t);
  endfunction

  function automatic logic [25:0] got_vec();
    return {heater, current_temp, remaining_time, busy, alarm};
  endfunction

  function automatic logic [25:0] exp_vec();
    return {m_heat, 10'(m_temp), 13'(m_rem), (m_mode != M_IDLE), m_alarm};
  endfunction

  task automatic model_to_done();
    m_mode = M_DONE; m_alarm = 1; m_req = 0; m_acnt = 0; m_rem = 0;
  endtask

  // Advance one clock; the model consumes the inputs present at that edge.
  task automatic step();
    bit tk, dh;
    int nt;
    @(posedge clk);
    tk = (m_pre == TICK_CYCLES - 1);
    dh = DOOR_EN && door_open;
    nt = m_temp;
    if (tk) begin
      if (m_heat) nt = (m_temp + HEAT_RATE > MAX_TEMP) ? MAX_TEMP : m_temp + HEAT_RATE;
      else        nt = (m_temp - COOL_RATE < AMBIENT)  ? AMBIENT  : m_temp - COOL_RATE;
    end
    m_pre = tk ? 0 : m_pre + 1;
    if (rst) begin
      m_pre = 0; m_temp = AMBIENT; m_mode = M_IDLE; m_req = 0;
      m_alarm = 0; m_rem = 0; m_acnt = 0; m_tgt = AMBIENT;
    end else begin
      m_temp = nt;
      if (cancel) begin
        m_mode = M_IDLE; m_req = 0; m_alarm = 0; m_rem = 0;
      end else begin
        case (m_mode)
          M_IDLE: if (start && !dh) begin
            m_tgt = clamp_t(int'(target_temp));
            m_rem = (int'(target_time) > MAX_TIME) ? MAX_TIME : int'(target_time);
            m_mode = M_PRE; m_req = 1;
          end
          M_PRE: if (tk && nt >= m_tgt) begin m_mode = M_COOK; m_req = 0; end
          M_COOK: begin
            if (m_rem == 0) model_to_done();
            else begin
              if (nt >= m_tgt) m_req = 0;
              else if (nt < m_tgt - HYST) m_req = 1;
              if (tk && !dh) begin
                m_rem--;
                if (m_rem == 0) model_to_done();
              end
            end
          end
          default: begin
            if (alarm_ack) begin m_mode = M_IDLE; m_alarm = 0; end
            else if (tk) begin
              m_acnt++;
              if (m_acnt == ALARM_TICKS) begin m_mode = M_IDLE; m_alarm = 0; end
            end
          end
        endcase
      end
    end
    m_heat = (m_mode == M_PRE || m_mode == M_COOK) && m_req && !dh;
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 0; cancel = 0; alarm_ack = 0; door_open = 0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (heater !== 1'b0) begin errors++; $display("FAIL reset_heater got %0b exp 0", heater); end
    checks++; if (current_temp !== 10'd65) begin errors++; $display("FAIL reset_temp got %0d exp 65", current_temp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got %0b exp 0", alarm); end
    checks++; if (remaining_time !== 13'd0) begin errors++; $display("FAIL reset_rem got %0d exp 0", remaining_time); end
  endtask

  task automatic test_basic_cycle();
    int alarm_cycles = 0, prev_mode;
    bit finished = 0;
    apply_reset();
    target_temp = 10'd100; target_time = 13'd3; start = 1;
    step(); start = 0;
    for (int i = 0; i < 600 && !finished; i++) begin
      prev_mode = m_mode;
      step();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL basic_cycle cyc %0d got %h exp %h", i, got_vec(), exp_vec());
      end
      if (prev_mode == M_PRE && m_mode == M_COOK) begin
        checks++;
        if (current_temp !== 10'd100 || remaining_time !== 13'd3)
          begin errors++; $display("FAIL basic_cook_entry got temp %0d rem %0d exp 100 3", current_temp, remaining_time); end
      end
      if (alarm === 1'b1) alarm_cycles++;
      if (prev_mode == M_DONE && m_mode == M_IDLE) finished = 1;
    end
    checks++;
    if (!finished || alarm_cycles != ALARM_TICKS * TICK_CYCLES) begin
      errors++; $display("FAIL basic_alarm_len got %0d cycles exp %0d", alarm_cycles, ALARM_TICKS * TICK_CYCLES);
    end
  endtask

  task automatic test_clamping();
    int cook_cycles = 0, max_seen = 0;
    apply_reset();
    target_temp = 10'($urandom_range(501, 1023));
    target_time = 13'($urandom_range(1801, 8191));
    start = 1; step(); start = 0;
    checks++;
    if (remaining_time !== 13'd1800) begin errors++; $display("FAIL clamp_time got %0d exp 1800", remaining_time); end
    for (int i = 0; i < 800 && cook_cycles < 200; i++) begin
      step();
      if (m_mode == M_COOK) cook_cycles++;
      if (int'(current_temp) > max_seen) max_seen = int'(current_temp);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL clamp_cycle cyc %0d got %h exp %h", i, got_vec(), exp_vec());
      end
    end
    checks++;
    if (max_seen != MAX_TEMP) begin errors++; $display("FAIL clamp_saturation got max %0d exp 500", max_seen); end
    cancel = 1; step(); cancel = 0;
  endtask

  task automatic test_hysteresis();
    int lo = 1023, hi = 0, cook_cycles = 0;
    bit saw_on = 0, saw_off = 0;
    apply_reset();
    target_temp = 10'd100; target_time = 13'd60;
    start = 1; step(); start = 0;
    for (int i = 0; i < 800 && cook_cycles < 220; i++) begin
      step();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL hyst_cycle cyc %0d got %h exp %h", i, got_vec(), exp_vec());
      end
      if (m_mode == M_COOK) begin
        cook_cycles++;
        if (int'(current_temp) < lo) lo = int'(current_temp);
        if (int'(current_temp) > hi) hi = int'(current_temp);
        if (heater === 1'b1) saw_on = 1;
        if (heater === 1'b0) saw_off = 1;
      end
    end
    checks++;
    if (cook_cycles < 220 || lo < 88 || hi > 105 || !saw_on || !saw_off) begin
      errors++; $display("FAIL hyst_band got [%0d,%0d] on %0b off %0b exp within [88,105] both", lo, hi, saw_on, saw_off);
    end
    cancel = 1; step(); cancel = 0;
  endtask

  task automatic test_cancel_restart();
    bit hit = 0;
    int t2;
    apply_reset();
    target_temp = 10'($urandom_range(66, 120)); target_time = 13'd4;
    start = 1; step(); start = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      step();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL cancel_run cyc %0d got %h exp %h", i, got_vec(), exp_vec());
      end
      if (m_mode == M_COOK && m_rem == 2) hit = 1;
    end
    cancel = 1; step(); cancel = 0;
    checks++;
    if (!hit || busy !== 1'b0 || heater !== 1'b0 || remaining_time !== 13'd0) begin
      errors++; $display("FAIL cancel_idle got busy %0b heat %0b rem %0d exp 0 0 0", busy, heater, remaining_time);
    end
    step();
    t2 = $urandom_range(1, 50);
    target_temp = 10'($urandom_range(66, 400)); target_time = 13'(t2);
    start = 1; step(); start = 0;
    checks++;
    if (busy !== 1'b1 || remaining_time !== 13'(t2) || heater !== 1'b1) begin
      errors++; $display("FAIL restart got busy %0b rem %0d heat %0b exp 1 %0d 1", busy, remaining_time, heater, t2);
    end
    cancel = 1; step(); cancel = 0;
  endtask

  task automatic test_zero_time_ack();
    bit hit = 0;
    apply_reset();
    target_temp = 10'($urandom_range(66, 100)); target_time = 13'd0;
    start = 1; step(); start = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      step();
      if (m_mode == M_COOK) hit = 1;
    end
    checks++;
    if (!hit || busy !== 1'b1 || alarm !== 1'b0) begin
      errors++; $display("FAIL zero_cook_entry got busy %0b alarm %0b exp 1 0", busy, alarm);
    end
    step();
    checks++;
    if (alarm !== 1'b1 || heater !== 1'b0 || remaining_time !== 13'd0) begin
      errors++; $display("FAIL zero_done got alarm %0b heat %0b rem %0d exp 1 0 0", alarm, heater, remaining_time);
    end
    alarm_ack = 1; step(); alarm_ack = 0;
    checks++;
    if (alarm !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ack_idle got alarm %0b busy %0b exp 0 0", alarm, busy);
    end
  endtask

`ifdef DOOR_INTERLOCK_EN
  task automatic test_door();
    bit hit = 0;
    logic [12:0] frozen;
    apply_reset();
    target_temp = 10'd100; target_time = 13'd20;
    start = 1; step(); start = 0;
    for (int i = 0; i < 600 && !hit; i++) begin
      step();
      if (m_mode == M_COOK) hit = 1;
    end
    step(); step();
    frozen = remaining_time;
    door_open = 1;
    for (int i = 0; i < 3 * TICK_CYCLES; i++) begin
      step();
      checks++;
      if (!hit || remaining_time !== frozen || heater !== 1'b0) begin
        errors++; $display("FAIL door_hold cyc %0d got rem %0d heat %0b exp %0d 0", i, remaining_time, heater, frozen);
      end
    end
    door_open = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL door_resume cyc %0d got %h exp %h", i, got_vec(), exp_vec());
      end
    end
    cancel = 1; step(); cancel = 0;
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      cancel    = ($urandom_range(0, 60) == 0);
      alarm_ack = ($urandom_range(0, 30) == 0);
      rst       = ($urandom_range(0, 700) == 0);
      if (DOOR_EN && $urandom_range(0, 15) == 0) door_open = ~door_open;
      target_temp = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(60, 140));
      target_time = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(0, 8191)) : 13'($urandom_range(0, 6));
      step();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", i, got_vec(), exp_vec());
      end
    end
    rst = 0; start = 0; cancel = 0; alarm_ack = 0; door_open = 0;
  endtask

  initial begin
    m_mode = M_IDLE; m_pre = 0; m_temp = AMBIENT; m_tgt = AMBIENT;
    m_rem = 0; m_acnt = 0; m_req = 0; m_heat = 0; m_alarm = 0;
    test_reset();
    test_basic_cycle();
    test_clamping();
    test_hysteresis();
    test_cancel_restart();
    test_zero_time_ack();
`ifdef DOOR_INTERLOCK_EN
    test_door();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
